// File: rtl/ps2_keyboard.sv
// ps2_keyboard -- PS/2 set-2 keyboard receiver with Apple-1 KBD/KBDCR registers.
//
// Deserialises PS/2 frames, tracks shift/extended/break prefixes, translates
// make codes to uppercase Apple-1 ASCII (bit 7 set) and queues the characters
// in a small FIFO for the CPU.
//
// Ports:
//   clk25      system clock
//   rst        synchronous active-high reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_data   raw PS/2 data (asynchronous)
//   enable     CPU clock-enable / chip-select strobe
//   r_en       CPU read strobe (active high)
//   address    0 = KBD (character), 1 = KBDCR (status)
//   dout       read data, combinational from registers
//   key_valid  FIFO non-empty, mirrors KBDCR bit 7
//   overflow   sticky flag: a character was dropped on a full FIFO
module ps2_keyboard #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 16384
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       enable,
    input  logic       r_en,
    input  logic       address,
    output logic [7:0] dout,
    output logic       key_valid,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Input synchronisers (idle level of both lines is high)
    // ------------------------------------------------------------------
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_s;
    logic       data_s;

    always_ff @(posedge clk25) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // ------------------------------------------------------------------
    // Clock glitch filter: the filtered level follows the synchronised
    // clock only after FILTER_LEN consecutive samples of the new level.
    // ------------------------------------------------------------------
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          filt_flip;
    logic          fall;

    assign filt_flip = (clk_s != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign fall      = filt_flip && clk_filt;

    always_ff @(posedge clk25) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            clk_filt <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame receiver FSM
    // ------------------------------------------------------------------
    rx_state_t     state;
    rx_state_t     state_next;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic          byte_done;
    logic          byte_stb;
    logic          timed_out;

    always_ff @(posedge clk25) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        byte_done  = 1'b0;
        timed_out  = (state != S_IDLE) && !fall && (to_cnt == TW'(TIMEOUT - 1));
        if (timed_out) begin
            state_next = S_IDLE;
        end else if (fall) begin
            case (state)
                S_IDLE:   if (!data_s) state_next = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
                // Odd parity: data bits plus parity bit hold an odd count of ones.
                S_PARITY: state_next = (^{shreg, data_s}) ? S_STOP : S_IDLE;
                S_STOP: begin
                    state_next = S_IDLE;
                    byte_done  = data_s;
                end
                default:  state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            to_cnt   <= '0;
            byte_stb <= 1'b0;
        end else begin
            byte_stb <= byte_done;
            to_cnt   <= (state_next == S_IDLE || fall) ? '0 : to_cnt + 1'b1;
            if (fall && state == S_IDLE) bit_cnt <= '0;
            if (fall && state == S_DATA) begin
                shreg   <= {data_s, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-code translation: {hit, ascii | 0x80}
    // ------------------------------------------------------------------
    function automatic logic [8:0] xlate(input logic [7:0] code, input logic shifted);
        logic       hit;
        logic [6:0] c;
        hit = 1'b1;
        c   = '0;
        case (code)
            8'h1C: c = 7'h41;  8'h32: c = 7'h42;  8'h21: c = 7'h43;  8'h23: c = 7'h44;
            8'h24: c = 7'h45;  8'h2B: c = 7'h46;  8'h34: c = 7'h47;  8'h33: c = 7'h48;
            8'h43: c = 7'h49;  8'h3B: c = 7'h4A;  8'h42: c = 7'h4B;  8'h4B: c = 7'h4C;
            8'h3A: c = 7'h4D;  8'h31: c = 7'h4E;  8'h44: c = 7'h4F;  8'h4D: c = 7'h50;
            8'h15: c = 7'h51;  8'h2D: c = 7'h52;  8'h1B: c = 7'h53;  8'h2C: c = 7'h54;
            8'h3C: c = 7'h55;  8'h2A: c = 7'h56;  8'h1D: c = 7'h57;  8'h22: c = 7'h58;
            8'h35: c = 7'h59;  8'h1A: c = 7'h5A;
            8'h16: c = shifted ? 7'h21 : 7'h31;
            8'h1E: c = shifted ? 7'h40 : 7'h32;
            8'h26: c = shifted ? 7'h23 : 7'h33;
            8'h25: c = shifted ? 7'h24 : 7'h34;
            8'h2E: c = shifted ? 7'h25 : 7'h35;
            8'h36: c = shifted ? 7'h5E : 7'h36;
            8'h3D: c = shifted ? 7'h26 : 7'h37;
            8'h3E: c = shifted ? 7'h2A : 7'h38;
            8'h46: c = shifted ? 7'h28 : 7'h39;
            8'h45: c = shifted ? 7'h29 : 7'h30;
            8'h41: c = shifted ? 7'h3C : 7'h2C;
            8'h49: c = shifted ? 7'h3E : 7'h2E;
            8'h4A: c = shifted ? 7'h3F : 7'h2F;
            8'h4C: c = shifted ? 7'h3A : 7'h3B;
            8'h52: c = shifted ? 7'h22 : 7'h27;
            8'h4E: c = shifted ? 7'h5F : 7'h2D;
            8'h55: c = shifted ? 7'h2B : 7'h3D;
            8'h29: c = 7'h20;
            8'h5A: c = 7'h0D;
            8'h66: c = 7'h5F;
            8'h76: c = 7'h1B;
            default: hit = 1'b0;
        endcase
        return {hit, 1'b1, c};
    endfunction

    // ------------------------------------------------------------------
    // Prefix/shift tracking and character generation
    // ------------------------------------------------------------------
    logic       ext;
    logic       brk;
    logic       shift_on;
    logic       char_wr;
    logic [7:0] char_data;
    logic [8:0] xl;

    assign xl = xlate(shreg, shift_on);

    always_ff @(posedge clk25) begin
        if (rst) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            shift_on  <= 1'b0;
            char_wr   <= 1'b0;
            char_data <= '0;
        end else begin
            char_wr <= 1'b0;
            if (byte_stb) begin
                if (shreg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk <= 1'b1;
                end else if (ext) begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end else if (shreg == 8'h12 || shreg == 8'h59) begin
                    shift_on <= ~brk;
                    brk      <= 1'b0;
                end else if (brk) begin
                    brk <= 1'b0;
                end else begin
                    char_wr   <= xl[8];
                    char_data <= xl[7:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Character FIFO and CPU register interface
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          rd_req;
    logic          rd_seen;
    logic          rd_act;
    logic          pop;
    logic          push;
    logic          full;

    assign rd_req    = enable & r_en;
    assign rd_act    = rd_req & ~rd_seen;
    assign key_valid = (count != '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = rd_act & ~address & key_valid;
    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign push      = char_wr & (~full | pop);

    always_ff @(posedge clk25) begin
        if (push) mem[wr_ptr] <= char_data;
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_seen  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (char_wr && !push)      overflow <= 1'b1;
            else if (rd_act && address) overflow <= 1'b0;
            if (rd_req)                rd_seen <= 1'b1;
            else if (!enable && !r_en) rd_seen <= 1'b0;
        end
    end

    always_comb begin
        dout = '0;
        if (address)        dout = {key_valid, overflow, 6'b0};
        else if (key_valid) dout = mem[rd_ptr];
    end

endmodule
